// File: rtl/alu_issue_if.sv
// Handshake/bus bundle between register-read, alu_issue and the ALU.
// master = alu_issue side (drives in_ready and the command bundle).
interface alu_issue_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] alu_in1;
    logic [XLEN-1:0] alu_in2;
    logic [3:0]      alu_op;
    logic [4:0]      alu_shamt;
    logic [15:0]     alu_imm;
    logic            alu_bne;
    logic            illegal;

    modport master (
        input  in_valid, instr, rs_data, rt_data, out_ready,
        output in_ready, out_valid, alu_in1, alu_in2, alu_op,
               alu_shamt, alu_imm, alu_bne, illegal
    );

    modport slave (
        output in_valid, instr, rs_data, rt_data, out_ready,
        input  in_ready, out_valid, alu_in1, alu_in2, alu_op,
               alu_shamt, alu_imm, alu_bne, illegal
    );
endinterface

// File: rtl/alu_issue.sv
// Decodes instr into an ALU command bundle behind a 2-entry (output + skid) buffer.
// Define ALU_ISSUE_IMM_ARITH_EN to also decode addi/addiu/slti/sltiu/andi/xori.
module alu_issue #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst,
    alu_issue_if.master  bus
);
    typedef struct packed {
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
        logic [3:0]      op;
        logic [4:0]      shamt;
        logic [15:0]     imm;
        logic            bne;
        logic            illegal;
    } bundle_t;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

    logic [5:0]      w_opc;
    logic [5:0]      w_funct;
    logic [15:0]     w_imm;
    logic [XLEN-1:0] w_sext;
    logic [XLEN-1:0] w_zext;
    logic            w_legal;
    logic [3:0]      w_op;
    logic [XLEN-1:0] w_in2;
    logic            w_bne;
    bundle_t         w_dec;
    logic            w_in_xfer;
    logic            w_out_xfer;

    state_t  r_state;
    bundle_t r_out;
    bundle_t r_skid;
    logic    r_out_valid;
    logic    r_in_ready;

    assign w_opc   = bus.instr[31:26];
    assign w_funct = bus.instr[5:0];
    assign w_imm   = bus.instr[15:0];
    assign w_sext  = {{(XLEN-16){w_imm[15]}}, w_imm};
    assign w_zext  = {{(XLEN-16){1'b0}}, w_imm};

    always_comb begin
        w_legal = 1'b1;
        w_op    = 4'h0;
        w_in2   = bus.rt_data;
        w_bne   = 1'b0;
        case (w_opc)
            6'h00: begin
                case (w_funct)
                    6'h00:        w_op = 4'h0;
                    6'h02:        w_op = 4'h1;
                    6'h03:        w_op = 4'h2;
                    6'h04:        w_op = 4'h3;
                    6'h06:        w_op = 4'h4;
                    6'h07:        w_op = 4'h5;
                    6'h20, 6'h21: w_op = 4'h6;
                    6'h22, 6'h23: w_op = 4'h7;
                    6'h24:        w_op = 4'h8;
                    6'h25:        w_op = 4'h9;
                    6'h26:        w_op = 4'hA;
                    6'h27:        w_op = 4'hB;
                    6'h2A:        w_op = 4'hC;
                    6'h2B:        w_op = 4'hD;
                    default:      w_legal = 1'b0;
                endcase
            end
            6'h04: w_op = 4'h7;
            6'h05: begin
                w_op  = 4'h7;
                w_bne = 1'b1;
            end
            6'h0F: begin
                w_op  = 4'hE;
                w_in2 = '0;
            end
            6'h0D: begin
                w_op  = 4'hF;
                w_in2 = w_zext;
            end
            6'h23, 6'h2B: begin
                w_op  = 4'h6;
                w_in2 = w_sext;
            end
`ifdef ALU_ISSUE_IMM_ARITH_EN
            6'h08, 6'h09: begin
                w_op  = 4'h6;
                w_in2 = w_sext;
            end
            6'h0A: begin
                w_op  = 4'hC;
                w_in2 = w_sext;
            end
            6'h0B: begin
                w_op  = 4'hD;
                w_in2 = w_sext;
            end
            6'h0C: begin
                w_op  = 4'h8;
                w_in2 = w_zext;
            end
            6'h0E: begin
                w_op  = 4'hA;
                w_in2 = w_zext;
            end
`endif
            default: w_legal = 1'b0;
        endcase
    end

    // Illegal bundles still flow through as a NOP with zeroed operands.
    always_comb begin
        w_dec         = '0;
        w_dec.shamt   = bus.instr[10:6];
        w_dec.imm     = w_imm;
        w_dec.illegal = !w_legal;
        if (w_legal) begin
            w_dec.in1 = bus.rs_data;
            w_dec.in2 = w_in2;
            w_dec.op  = w_op;
            w_dec.bne = w_bne;
        end
    end

    assign w_in_xfer  = bus.in_valid & r_in_ready;
    assign w_out_xfer = r_out_valid & bus.out_ready;

    // in_ready is low only in FULL, so FULL never sees an input transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_out       <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_in_xfer) begin
                        r_out       <= w_dec;
                        r_out_valid <= 1'b1;
                        r_state     <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        r_out <= w_dec;
                    end else if (w_in_xfer) begin
                        r_skid     <= w_dec;
                        r_in_ready <= 1'b0;
                        r_state    <= S_FULL;
                    end else if (w_out_xfer) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (w_out_xfer) begin
                        r_out      <= r_skid;
                        r_in_ready <= 1'b1;
                        r_state    <= S_ONE;
                    end
                end
                default: begin
                    r_state     <= S_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.alu_in1   = r_out.in1;
    assign bus.alu_in2   = r_out.in2;
    assign bus.alu_op    = r_out.op;
    assign bus.alu_shamt = r_out.shamt;
    assign bus.alu_imm   = r_out.imm;
    assign bus.alu_bne   = r_out.bne;
    assign bus.illegal   = r_out.illegal;
endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: table-driven decode model, random traffic and backpressure.
module tb_alu_issue;
    typedef struct packed {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [3:0]  op;
        logic [4:0]  shamt;
        logic [15:0] imm;
        logic        bne;
        logic        ill;
    } bun_t;

    localparam int K_RT = 0, K_Z = 1, K_S = 2, K_0 = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_issue_if #(.XLEN(32)) bus ();
    alu_issue #(.XLEN(32)) dut (.clk(clk), .rst(rst), .bus(bus.master));

    bun_t exp_q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   rtab[64];
    int   itab[64];
    int   ikind[64];
    bit   rnd_done;

    function automatic void init_tables();
        for (int i = 0; i < 64; i++) begin
            rtab[i] = -1; itab[i] = -1; ikind[i] = K_RT;
        end
        rtab[0] = 0;   rtab[2] = 1;   rtab[3] = 2;   rtab[4] = 3;
        rtab[6] = 4;   rtab[7] = 5;   rtab[32] = 6;  rtab[33] = 6;
        rtab[34] = 7;  rtab[35] = 7;  rtab[36] = 8;  rtab[37] = 9;
        rtab[38] = 10; rtab[39] = 11; rtab[42] = 12; rtab[43] = 13;
        itab[4] = 7;   itab[5] = 7;
        itab[15] = 14; ikind[15] = K_0;
        itab[13] = 15; ikind[13] = K_Z;
        itab[35] = 6;  ikind[35] = K_S;
        itab[43] = 6;  ikind[43] = K_S;
`ifdef ALU_ISSUE_IMM_ARITH_EN
        itab[8] = 6;   ikind[8] = K_S;
        itab[9] = 6;   ikind[9] = K_S;
        itab[10] = 12; ikind[10] = K_S;
        itab[11] = 13; ikind[11] = K_S;
        itab[12] = 8;  ikind[12] = K_Z;
        itab[14] = 10; ikind[14] = K_Z;
`endif
    endfunction

    function automatic bun_t model(logic [31:0] ins, logic [31:0] rs, logic [31:0] rt);
        bun_t m;
        int   opc, op, k, v;
        opc = int'(ins[31:26]);
        v   = int'(ins[15:0]);
        m   = '0;
        m.shamt = ins[10:6];
        m.imm   = ins[15:0];
        if (opc == 0) begin
            op = rtab[ins[5:0]]; k = K_RT;
        end else begin
            op = itab[opc]; k = ikind[opc];
        end
        if (op < 0) begin
            m.ill = 1'b1;
        end else begin
            m.op  = op[3:0];
            m.in1 = rs;
            m.bne = (opc == 5);
            case (k)
                K_RT:    m.in2 = rt;
                K_Z:     m.in2 = v;
                K_S:     m.in2 = (v >= 32768) ? v - 65536 : v;
                default: m.in2 = 0;
            endcase
        end
        return m;
    endfunction

    function automatic void check(string nm, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", nm, got, exp);
    endfunction

    // Input capture: transfer happens at the next posedge.
    always @(negedge clk) begin
        if (!rst && bus.in_valid && bus.in_ready)
            exp_q.push_back(model(bus.instr, bus.rs_data, bus.rt_data));
    end

    // Output monitor.
    always @(negedge clk) begin
        bun_t got, e;
        if (!rst && bus.out_valid && bus.out_ready) begin
            got = '{in1: bus.alu_in1, in2: bus.alu_in2, op: bus.alu_op, shamt: bus.alu_shamt,
                    imm: bus.alu_imm, bne: bus.alu_bne, ill: bus.illegal};
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL bundle_unexpected got=%h", got);
            end else begin
                e = exp_q.pop_front();
                if (got === e) n_pass++;
                else $display("FAIL bundle got=%h exp=%h", got, e);
            end
        end
    end

    task automatic send(logic [31:0] ins, logic [31:0] rs, logic [31:0] rt);
        int t;
        t = 0;
        bus.instr = ins; bus.rs_data = rs; bus.rt_data = rt; bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            n_chk++;
            $display("FAIL send_timeout got=in_ready 0 exp=in_ready 1");
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        int ops[17] = '{0, 0, 0, 4, 5, 15, 13, 35, 43, 8, 9, 10, 11, 12, 14, 63, 1};
        int fns[19] = '{0, 2, 3, 4, 6, 7, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 1, 5, 8};
        logic [31:0] ins;
        int opc;
        ins = $urandom;
        opc = ops[$urandom_range(0, 16)];
        ins[31:26] = opc[5:0];
        if (opc == 0) ins[5:0] = 6'(fns[$urandom_range(0, 18)]);
        return ins;
    endfunction

    initial begin
        init_tables();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.instr = '0; bus.rs_data = '0; bus.rt_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_in_ready", 64'(bus.in_ready), 64'd1);
        check("reset_data", 64'({bus.alu_in1, bus.alu_op, bus.alu_shamt, bus.alu_imm,
                                 bus.alu_bne, bus.illegal}), 64'd0);
        check("reset_in2", 64'(bus.alu_in2), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed decode cases.
        bus.out_ready = 1'b1;
        send(32'h00851020, 32'd5, 32'd7);
        check("add_latency", 64'(bus.out_valid), 64'd1);
        check("add_fields", {bus.alu_in1, bus.alu_in2}, {32'd5, 32'd7});
        check("add_op", 64'({bus.alu_op, bus.alu_bne, bus.illegal}), 64'({4'h6, 1'b0, 1'b0}));
        send(32'h14A6FFFF, 32'd11, 32'd12);
        check("bne_op", 64'({bus.alu_op, bus.alu_bne, bus.alu_imm}), 64'({4'h7, 1'b1, 16'hFFFF}));
        send(32'h8C22FFFC, 32'h100, 32'd0);
        check("lw_in2", 64'(bus.alu_in2), 64'hFFFFFFFC);
        check("lw_op", 64'(bus.alu_op), 64'h6);
        send(32'hFC000000, 32'd1, 32'd2);
        check("illegal_flag", 64'({bus.illegal, bus.alu_op}), 64'({1'b1, 4'h0}));
        send(32'h2002FFFF, 32'd3, 32'd9);
`ifdef ALU_ISSUE_IMM_ARITH_EN
        check("addi_op", 64'({bus.illegal, bus.alu_op}), 64'({1'b0, 4'h6}));
        check("addi_in2", 64'(bus.alu_in2), 64'hFFFFFFFF);
`else
        check("addi_illegal", 64'({bus.illegal, bus.alu_op}), 64'({1'b1, 4'h0}));
`endif
        @(posedge clk); #1;

        // Backpressure: in_ready drops after the second bundle is accepted.
        bus.out_ready = 1'b0;
        send(32'h00430820, 32'd1, 32'd2);
        check("bp_ready_after_1", 64'(bus.in_ready), 64'd1);
        send(32'h00430822, 32'd3, 32'd4);
        check("bp_ready_after_2", 64'(bus.in_ready), 64'd0);
        fork
            send(32'h00430825, 32'd5, 32'd6);
            begin
                repeat (3) @(posedge clk);
                #1;
                check("bp_hold_ready", 64'({bus.in_ready, bus.out_valid}), 64'({1'b0, 1'b1}));
                bus.out_ready = 1'b1;
            end
        join
        repeat (5) @(posedge clk);
        #1;
        check("bp_drained", 64'(exp_q.size()), 64'd0);

        // Mid-stream reset from FULL.
        bus.out_ready = 1'b0;
        send(32'h00430824, 32'd7, 32'd8);
        send(32'h00430826, 32'd9, 32'd10);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mid_state", 64'({bus.out_valid, bus.in_ready}), 64'({1'b0, 1'b1}));
        check("rst_mid_data", 64'(bus.alu_in1 | bus.alu_in2), 64'd0);

        // Random traffic with random backpressure.
        rnd_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    send(rand_instr(), $urandom, $urandom);
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        for (int t = 0; t < 50 && (exp_q.size() != 0 || bus.out_valid); t++) begin
            @(posedge clk); #1;
        end
        check("final_drain", 64'({bus.out_valid, 31'(exp_q.size())}), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
